// File: rtl/enc7led.sv
// Nibble to seven-segment encoder with a single registered output.
// Hex mode shows 0-F glyphs; decimal mode shows 0-9 and a dash for 10-15.
module enc7led #(
   parameter bit ACTIVE_LOW = 1'b1
) (
   input  logic       sysclk,
   input  logic       rst,
   input  logic [3:0] vinp,
   input  logic       enchx,
   output logic [6:0] leds
);

   localparam logic [6:0] LEDS_OFF = ACTIVE_LOW ? 7'h7F : 7'h00;

   logic [6:0] glyph_s;
   logic [6:0] leds_d;
   logic [6:0] leds_q;

   // Active-high gfedcba pattern for each nibble value
   function automatic logic [6:0] hex_glyph(input logic [3:0] v);
      logic [6:0] g;
      case (v)
         4'h0:    g = 7'h3F;
         4'h1:    g = 7'h06;
         4'h2:    g = 7'h5B;
         4'h3:    g = 7'h4F;
         4'h4:    g = 7'h66;
         4'h5:    g = 7'h6D;
         4'h6:    g = 7'h7D;
         4'h7:    g = 7'h07;
         4'h8:    g = 7'h7F;
         4'h9:    g = 7'h6F;
         4'hA:    g = 7'h77;
         4'hB:    g = 7'h7C;
         4'hC:    g = 7'h39;
         4'hD:    g = 7'h5E;
         4'hE:    g = 7'h79;
         4'hF:    g = 7'h71;
         default: g = 7'h00;
      endcase
      return g;
   endfunction

   // Glyph selection and polarity mapping
   always_comb begin
      glyph_s = 7'h00;
      leds_d  = LEDS_OFF;
      if (!enchx && (vinp > 4'd9)) begin
         glyph_s = 7'h40;
      end else begin
         glyph_s = hex_glyph(vinp);
      end
      if (ACTIVE_LOW) begin
         leds_d = ~glyph_s;
      end else begin
         leds_d = glyph_s;
      end
   end

   // Output register, forced dark while reset is held
   always_ff @(posedge sysclk or posedge rst) begin
      if (rst) begin
         leds_q <= LEDS_OFF;
      end else begin
         leds_q <= leds_d;
      end
   end

   assign leds = leds_q;

endmodule

// File: tb/tb_enc7led.sv
// Self-checking bench for enc7led: both polarities driven from shared inputs,
// directed scenarios plus randomized stimulus against a table-based model.
module tb_enc7led;

   logic       sysclk;
   logic       rst;
   logic [3:0] vinp;
   logic       enchx;
   logic [6:0] leds_l;
   logic [6:0] leds_h;

   int checks;
   int errors;

   enc7led #(.ACTIVE_LOW(1'b1)) dut_l (
      .sysclk(sysclk), .rst(rst), .vinp(vinp), .enchx(enchx), .leds(leds_l)
   );

   enc7led #(.ACTIVE_LOW(1'b0)) dut_h (
      .sysclk(sysclk), .rst(rst), .vinp(vinp), .enchx(enchx), .leds(leds_h)
   );

   initial sysclk = 1'b0;
   always #5 sysclk = ~sysclk;

   // Reference: glyph table straight from the segment chart, then polarity
   function automatic logic [6:0] model(input int v, input bit hex, input bit active_low);
      logic [6:0] table_g [16];
      logic [6:0] g;
      table_g = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                  7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
      if (!hex && v >= 10) g = 7'h40;
      else                 g = table_g[v];
      return active_low ? ~g : g;
   endfunction

   task automatic tick();
      @(posedge sysclk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b0; vinp = 4'd0; enchx = 1'b1;
      @(posedge sysclk);
      #3;
      rst = 1'b1;
      #1;
      checks++;
      if (leds_l !== 7'h7F) begin
         errors++; $display("FAIL reset_async_low: got %h want 7f", leds_l);
      end
      checks++;
      if (leds_h !== 7'h00) begin
         errors++; $display("FAIL reset_async_high: got %h want 00", leds_h);
      end
      tick();
      checks++;
      if (leds_l !== 7'h7F) begin
         errors++; $display("FAIL reset_held: got %h want 7f", leds_l);
      end
      @(negedge sysclk);
      rst = 1'b0; vinp = 4'd0; enchx = 1'b1;
      tick();
      checks++;
      if (leds_l !== 7'h40) begin
         errors++; $display("FAIL reset_release: got %h want 40", leds_l);
      end
   endtask

   task automatic test_hex_sweep();
      logic [6:0] seq [16];
      seq = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
              7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
      for (int i = 0; i < 16; i++) begin
         @(negedge sysclk);
         vinp = 4'(i); enchx = 1'b1;
         #2;
         if (i > 0) begin
            checks++;
            if (leds_l !== seq[i-1]) begin
               errors++; $display("FAIL hex_lag v=%0d: got %h want %h", i, leds_l, seq[i-1]);
            end
         end
         tick();
         checks++;
         if (leds_l !== seq[i]) begin
            errors++; $display("FAIL hex_sweep v=%0d: got %h want %h", i, leds_l, seq[i]);
         end
      end
   endtask

   task automatic test_decimal();
      @(negedge sysclk);
      vinp = 4'd9; enchx = 1'b0;
      tick();
      checks++;
      if (leds_l !== 7'h10) begin
         errors++; $display("FAIL dec_nine: got %h want 10", leds_l);
      end
      for (int v = 10; v < 16; v++) begin
         @(negedge sysclk);
         vinp = 4'(v);
         tick();
         checks++;
         if (leds_l !== 7'h3F) begin
            errors++; $display("FAIL dec_dash v=%0d: got %h want 3f", v, leds_l);
         end
         checks++;
         if (leds_h !== 7'h40) begin
            errors++; $display("FAIL dec_dash_high v=%0d: got %h want 40", v, leds_h);
         end
      end
   endtask

   task automatic test_polarity();
      @(negedge sysclk);
      vinp = 4'd8; enchx = 1'b1;
      tick();
      checks++;
      if (leds_h !== 7'h7F) begin
         errors++; $display("FAIL pol_eight: got %h want 7f", leds_h);
      end
      @(negedge sysclk);
      vinp = 4'd1;
      tick();
      checks++;
      if (leds_h !== 7'h06) begin
         errors++; $display("FAIL pol_one: got %h want 06", leds_h);
      end
      #2;
      rst = 1'b1;
      #1;
      checks++;
      if (leds_h !== 7'h00) begin
         errors++; $display("FAIL pol_reset: got %h want 00", leds_h);
      end
      @(negedge sysclk);
      rst = 1'b0;
      tick();
   endtask

   task automatic test_latency();
      @(negedge sysclk);
      vinp = 4'hC; enchx = 1'b1;
      tick();
      checks++;
      if (leds_l !== 7'h46) begin
         errors++; $display("FAIL lat_start: got %h want 46", leds_l);
      end
      @(negedge sysclk);
      enchx = 1'b0;
      for (int t = 0; t < 4; t++) begin
         #1;
         checks++;
         if (leds_l !== 7'h46) begin
            errors++; $display("FAIL lat_hold t=%0d: got %h want 46", t, leds_l);
         end
      end
      tick();
      checks++;
      if (leds_l !== 7'h3F) begin
         errors++; $display("FAIL lat_update: got %h want 3f", leds_l);
      end
   endtask

   task automatic test_reset_midstream();
      for (int i = 0; i < 6; i++) begin
         @(negedge sysclk);
         vinp = 4'(i); enchx = 1'b1;
         tick();
      end
      #2;
      rst = 1'b1;
      #1;
      checks++;
      if (leds_l !== 7'h7F) begin
         errors++; $display("FAIL mid_reset: got %h want 7f", leds_l);
      end
      @(negedge sysclk);
      vinp = 4'd6;
      tick();
      checks++;
      if (leds_l !== 7'h7F) begin
         errors++; $display("FAIL mid_override: got %h want 7f", leds_l);
      end
      @(negedge sysclk);
      rst = 1'b0;
      tick();
      checks++;
      if (leds_l !== model(6, 1'b1, 1'b1)) begin
         errors++; $display("FAIL mid_release: got %h want %h", leds_l, model(6, 1'b1, 1'b1));
      end
   endtask

   task automatic test_random();
      int  v;
      bit  h;
      bit  r;
      logic [6:0] exp_l;
      logic [6:0] exp_h;
      for (int n = 0; n < 300; n++) begin
         @(negedge sysclk);
         v = int'($urandom_range(0, 15));
         h = 1'($urandom_range(0, 1));
         r = ($urandom_range(0, 15) == 0);
         vinp = 4'(v); enchx = h; rst = r;
         tick();
         exp_l = r ? 7'h7F : model(v, h, 1'b1);
         exp_h = r ? 7'h00 : model(v, h, 1'b0);
         checks++;
         if (leds_l !== exp_l) begin
            errors++; $display("FAIL rand_low n=%0d v=%0d h=%0d r=%0d: got %h want %h", n, v, h, r, leds_l, exp_l);
         end
         checks++;
         if (leds_h !== exp_h) begin
            errors++; $display("FAIL rand_high n=%0d v=%0d h=%0d r=%0d: got %h want %h", n, v, h, r, leds_h, exp_h);
         end
      end
      @(negedge sysclk);
      rst = 1'b0;
   endtask

   initial begin
      checks = 0;
      errors = 0;
      test_reset();
      test_hex_sweep();
      test_decimal();
      test_polarity();
      test_latency();
      test_reset_midstream();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
